// File: rtl/risc_pipe_ctrl.sv
// rtl/risc_pipe_ctrl.sv - pipeline hazard/flush/debug-halt sequencing controller (optional RISC_PIPE_PERF_EN counters)
module risc_pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [REG_AW-1:0] AA,
  input  logic [REG_AW-1:0] BA,
  input  logic              MA,
  input  logic              MB,
  input  logic              RW_ex,
  input  logic [REG_AW-1:0] DA_ex,
  input  logic [1:0]        MD_ex,
  input  logic              br_resolve,
  input  logic              br_taken,
  input  logic              br_predicted,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              perf_clr,
  output logic              stall_if,
  output logic              stall_dof,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic              flush_dof,
  output logic              halted,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  state_t state;
  logic   mispredict;
  logic   load_use;

  // Hazard detection: wrong-path branch in EX, and a load in EX feeding a DOF register operand
  always_comb begin
    mispredict = br_resolve & (br_taken != br_predicted);
    load_use   = RW_ex & (MD_ex == 2'b01) & (DA_ex != '0) &
                 ((~MA & (AA == DA_ex)) | (~MB & (BA == DA_ex)));
  end

  // Pipeline enables: mispredict squashes the front end, otherwise load-use or halt freezes it
  always_comb begin
    stall_if  = 1'b0;
    stall_dof = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_dof = 1'b0;
    if (!reset) begin
      if (mispredict) begin
        flush_if  = 1'b1;
        flush_dof = 1'b1;
      end else if (load_use || state == HALT) begin
        stall_if  = 1'b1;
        stall_dof = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  // Debug state machine; halted mirrors the state being entered so it is valid while in HALT
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req && !mispredict && !load_use) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end else if (step_req) begin
            state  <= STEP;
            halted <= 1'b0;
          end
        end
        STEP: begin
          // The stepped instruction only advances in a cycle that is not held by load-use
          if (mispredict || !load_use) begin
            state  <= halt_req ? HALT : RUN;
            halted <= halt_req;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef RISC_PIPE_PERF_EN
  // Performance counters: clear beats increment, all wrap naturally
  always_ff @(posedge CLK) begin
    if (reset || perf_clr) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt   <= cyc_cnt + CNT_W'(1);
      stall_cnt <= stall_cnt + CNT_W'(stall_if);
      flush_cnt <= flush_cnt + CNT_W'(flush_if);
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_risc_pipe_ctrl.sv
// tb/tb_risc_pipe_ctrl.sv - scoreboard bench for risc_pipe_ctrl with a rule-level reference model
module tb_risc_pipe_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] AA, BA, DA_ex;
  logic              MA, MB, RW_ex;
  logic [1:0]        MD_ex;
  logic              br_resolve, br_taken, br_predicted;
  logic              halt_req, step_req, perf_clr;
  logic              stall_if, stall_dof, bubble_ex, flush_if, flush_dof, halted;
  logic [CNT_W-1:0]  cyc_cnt, stall_cnt, flush_cnt;

  risc_pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .AA(AA), .BA(BA), .MA(MA), .MB(MB),
    .RW_ex(RW_ex), .DA_ex(DA_ex), .MD_ex(MD_ex),
    .br_resolve(br_resolve), .br_taken(br_taken), .br_predicted(br_predicted),
    .halt_req(halt_req), .step_req(step_req), .perf_clr(perf_clr),
    .stall_if(stall_if), .stall_dof(stall_dof), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_dof(flush_dof), .halted(halted),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int sif, sdof, bub, fif, fdof, hlt, cyc, stl, fls;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: debug mode as a name and counters as plain integers
  string mode = "run";
  int    m_cyc = 0, m_stl = 0, m_fls = 0;
  int    wrap = 1 << CNT_W;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic idle();
    reset = 0; AA = 0; BA = 0; MA = 0; MB = 0; RW_ex = 0; DA_ex = 0; MD_ex = 0;
    br_resolve = 0; br_taken = 0; br_predicted = 0;
    halt_req = 0; step_req = 0; perf_clr = 0;
  endtask

  // Compute this cycle's expected outputs from the rules, queue them, advance the model
  task automatic eval();
    exp_t e;
    bit mp, lu, stall, stall_free;
    mp = br_resolve && (br_taken != br_predicted);
    lu = RW_ex && (MD_ex == 2'd1) && (DA_ex != 0) &&
         ((!MA && AA == DA_ex) || (!MB && BA == DA_ex));
    e.hlt = (mode == "halt");
    e.cyc = 0; e.stl = 0; e.fls = 0;
`ifdef RISC_PIPE_PERF_EN
    e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls;
`endif
    if (reset) begin
      e.sif = 0; e.sdof = 0; e.bub = 0; e.fif = 0; e.fdof = 0;
      mode = "run";
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else begin
      stall = !mp && (lu || mode == "halt");
      e.sif = stall; e.sdof = stall; e.bub = stall;
      e.fif = mp; e.fdof = mp;
      stall_free = !(lu && !mp);
      if (mode == "run") begin
        if (halt_req && !mp && !lu) mode = "halt";
      end else if (mode == "halt") begin
        if (!halt_req) mode = "run";
        else if (step_req) mode = "step";
      end else begin
        if (stall_free) mode = halt_req ? "halt" : "run";
      end
      if (perf_clr) begin
        m_cyc = 0; m_stl = 0; m_fls = 0;
      end else begin
        m_cyc = (m_cyc + 1) % wrap;
        m_stl = (m_stl + (stall ? 1 : 0)) % wrap;
        m_fls = (m_fls + (mp ? 1 : 0)) % wrap;
      end
    end
    q.push_back(e);
  endtask

  // Monitor: compare the DUT mid-cycle against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("stall_if",  int'(stall_if),  e.sif);
        check("stall_dof", int'(stall_dof), e.sdof);
        check("bubble_ex", int'(bubble_ex), e.bub);
        check("flush_if",  int'(flush_if),  e.fif);
        check("flush_dof", int'(flush_dof), e.fdof);
        check("halted",    int'(halted),    e.hlt);
        check("cyc_cnt",   int'(cyc_cnt),   e.cyc);
        check("stall_cnt", int'(stall_cnt), e.stl);
        check("flush_cnt", int'(flush_cnt), e.fls);
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      eval();
    end
  endtask

  // Helper: advance one clock, let the caller set inputs, then evaluate
  task automatic next();
    @(posedge CLK); #1;
  endtask

  initial begin
    int waited;
    idle();
    reset = 1;
    next(); eval();
    next(); eval();
    // Load-use on AA, then DA_ex=0, then MA=1 masking
    next(); idle(); RW_ex = 1; MD_ex = 2'b01; DA_ex = 5; AA = 5; eval();
    next(); DA_ex = 0; AA = 0; eval();
    next(); DA_ex = 5; AA = 5; MA = 1; eval();
    next(); MA = 0; MB = 0; BA = 5; AA = 1; eval();
    // Mispredict, correct prediction, and mispredict with load-use
    next(); idle(); br_resolve = 1; br_taken = 1; eval();
    next(); br_predicted = 1; eval();
    next(); br_predicted = 0; RW_ex = 1; MD_ex = 2'b01; DA_ex = 7; AA = 7; eval();
    // Halt, hold, single step, re-halt, release
    next(); idle(); halt_req = 1; eval();
    cyc(3);
    next(); step_req = 1; eval();
    next(); step_req = 0; eval();
    cyc(3);
    // Step while a load-use holds the stepped instruction
    next(); step_req = 1; eval();
    next(); step_req = 0; RW_ex = 1; MD_ex = 2'b01; DA_ex = 3; BA = 3; eval();
    next(); RW_ex = 0; eval();
    cyc(2);
    next(); halt_req = 0; eval();
    cyc(2);
    // Reset in HALT with halt_req held, then re-halt after release
    next(); halt_req = 1; eval();
    cyc(2);
    next(); reset = 1; eval();
    next(); reset = 0; eval();
    cyc(3);
    next(); idle(); eval();
    // Counter wrap, three load-use stalls, clear
    cyc(18);
    for (int i = 0; i < 3; i++) begin
      next(); RW_ex = 1; MD_ex = 2'b01; DA_ex = 9; AA = 9; eval();
    end
    next(); idle(); perf_clr = 1; eval();
    next(); perf_clr = 0; eval();
    // Randomized traffic with biased operand matching
    for (int i = 0; i < 3000; i++) begin
      next();
      reset        = ($urandom_range(0, 99) == 0);
      AA           = REG_AW'($urandom_range(0, 3));
      BA           = REG_AW'($urandom_range(0, 3));
      DA_ex        = REG_AW'($urandom_range(0, 3));
      MA           = ($urandom_range(0, 3) == 0);
      MB           = ($urandom_range(0, 3) == 0);
      RW_ex        = ($urandom_range(0, 2) != 0);
      MD_ex        = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      br_resolve   = ($urandom_range(0, 3) == 0);
      br_taken     = 1'($urandom_range(0, 1));
      br_predicted = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      step_req     = ($urandom_range(0, 5) == 0);
      perf_clr     = ($urandom_range(0, 40) == 0);
      eval();
    end
    next(); idle();
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge CLK);
      waited++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
